// File: rtl/pde_converge_ctrl.sv
// Purpose : convergence controller behind the 5x5 PE array. It tracks the per-iteration
//           max |delta| of the live grid, ends a solve on tolerance or on the iteration cap,
//           then streams the frozen 25-word frame row-major.
// Latency : start -> busy 1 cycle; exit edge -> word 0 on out_valid in the next cycle; done
//           pulses in the cycle after the word-24 handshake.
// Backpressure: out_ready low stalls the stream with data/row/col/last held; there are no
//           bubbles between accepted words.
//
// Ports   : CLK, R (async active-low reset), start, tol (unsigned, latched at start),
//           uij[row][col] (signed DW-bit live grid), busy, done, converged, iter_count,
//           max_diff, out_valid/out_ready/out_data/out_row/out_col/out_last (result stream).
// Config  : PDE_CONV_DETECT_EN enables tolerance early exit. When it is undefined, every
//           solve runs exactly MAX_ITER cycles, converged stays 0 and max_diff is tied to 0.
module pde_converge_ctrl #(
    parameter int N        = 5,
    parameter int DW       = 16,
    parameter int MAX_ITER = 1024,
    parameter int ITW      = 11,
    parameter int STABLE   = 4
) (
    input  logic                          CLK,
    input  logic                          R,
    input  logic                          start,
    input  logic [DW-1:0]                 tol,
    input  logic [N-1:0][N-1:0][DW-1:0]   uij,
    output logic                          busy,
    output logic                          done,
    output logic                          converged,
    output logic [ITW-1:0]                iter_count,
    output logic [DW-1:0]                 max_diff,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DW-1:0]                 out_data,
    output logic [2:0]                    out_row,
    output logic [2:0]                    out_col,
    output logic                          out_last
);

    localparam int CELLS = N * N;
    localparam int IDXW  = $clog2(CELLS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [IDXW-1:0] idx;
    logic [DW-1:0]   frame [CELLS];
    logic            cap_hit;
    logic            conv_hit;

    assign cap_hit = (iter_count == ITW'(MAX_ITER - 1));

`ifdef PDE_CONV_DETECT_EN
    localparam int SCW = $clog2(STABLE + 1);

    logic [N-1:0][N-1:0][DW-1:0] snap;
    logic [DW-1:0]               tol_q;
    logic [SCW-1:0]              stable_cnt;
    logic [DW:0]                 cell_d   [N][N];
    logic [DW-1:0]               cell_mag [N][N];
    logic [DW-1:0]               diff_max;
    logic                        cmp_pass;

    // One extra bit keeps the signed difference exact: its magnitude tops out at
    // 2^DW - 1 (0x7FFF -> 0x8000), which still fits DW bits unsigned.
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign cell_d[r][c]   = {uij[r][c][DW-1], uij[r][c]} - {snap[r][c][DW-1], snap[r][c]};
            assign cell_mag[r][c] = cell_d[r][c][DW] ? DW'(-cell_d[r][c]) : cell_d[r][c][DW-1:0];
        end
    end

    always_comb begin
        diff_max = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (cell_mag[r][c] > diff_max) begin
                    diff_max = cell_mag[r][c];
                end
            end
        end
    end

    // Iteration 0 only seeds the snapshot, so it never counts as a passing compare.
    assign cmp_pass = (iter_count != '0) && (diff_max <= tol_q);
    assign conv_hit = cmp_pass && (stable_cnt == SCW'(STABLE - 1));

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            snap       <= '0;
            tol_q      <= '0;
            stable_cnt <= '0;
            max_diff   <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                tol_q      <= tol;
                stable_cnt <= '0;
            end
        end else if (state == S_RUN) begin
            snap <= uij;
            if (iter_count != '0) begin
                max_diff   <= diff_max;
                stable_cnt <= cmp_pass ? stable_cnt + 1'b1 : '0;
            end
        end
    end
`else
    logic            unused_tol;
    localparam int   unused_stable = STABLE;

    assign unused_tol = ^tol;
    assign conv_hit   = 1'b0;
    assign max_diff   = '0;
`endif

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            converged  <= 1'b0;
            iter_count <= '0;
            idx        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
            for (int i = 0; i < CELLS; i++) begin
                frame[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RUN;
                        busy       <= 1'b1;
                        iter_count <= '0;
                        converged  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (conv_hit || cap_hit) begin
                        // Convergence takes priority when both exits land on the same cycle.
                        state     <= S_DRAIN;
                        converged <= conv_hit;
                        for (int r = 0; r < N; r++) begin
                            for (int c = 0; c < N; c++) begin
                                frame[r*N + c] <= uij[r][c];
                            end
                        end
                        // Word 0 comes straight from the grid so it is presented on the
                        // first DRAIN cycle without waiting for the frame write.
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_data  <= uij[0][0];
                        out_row   <= '0;
                        out_col   <= '0;
                        out_last  <= 1'b0;
                    end else begin
                        iter_count <= iter_count + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_valid && out_ready) begin
                        if (idx == IDXW'(CELLS - 1)) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            idx      <= idx + 1'b1;
                            out_data <= frame[idx + 1'b1];
                            out_last <= (idx + 1'b1) == IDXW'(CELLS - 1);
                            if (out_col == 3'(N - 1)) begin
                                out_col <= '0;
                                out_row <= out_row + 3'd1;
                            end else begin
                                out_col <= out_col + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pde_converge_ctrl.sv
module tb_pde_converge_ctrl;

    localparam int N        = 5;
    localparam int DW       = 16;
    localparam int MAX_ITER = 16;
    localparam int ITW      = 5;
    localparam int STABLE   = 4;
`ifdef PDE_CONV_DETECT_EN
    localparam bit DET = 1'b1;
`else
    localparam bit DET = 1'b0;
`endif

    logic                        CLK = 1'b0;
    logic                        R;
    logic                        start;
    logic [DW-1:0]               tol;
    logic [N-1:0][N-1:0][DW-1:0] uij;
    logic                        busy, done, converged;
    logic [ITW-1:0]              iter_count;
    logic [DW-1:0]               max_diff;
    logic                        out_valid, out_ready, out_last;
    logic [DW-1:0]               out_data;
    logic [2:0]                  out_row, out_col;

    pde_converge_ctrl #(.N(N), .DW(DW), .MAX_ITER(MAX_ITER), .ITW(ITW), .STABLE(STABLE)) dut (
        .CLK(CLK), .R(R), .start(start), .tol(tol), .uij(uij),
        .busy(busy), .done(done), .converged(converged), .iter_count(iter_count),
        .max_diff(max_diff), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] w; } word_t;            // {data,row,col,last}
    typedef struct { int iter; logic conv; int md; } sum_t;

    int          checks = 0;
    int          errors = 0;
    word_t       exp_q[$];
    sum_t        sum_q[$];
    int          ready_mode = 0;
    int          stall_left = 0;
    int          done_seen  = 0;
    int          drain_len  = 0;
    logic [15:0] g [MAX_ITER][N][N];
    int          dk [MAX_ITER];
    int          k_exit;
    logic        exp_conv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] pack_word(input logic [15:0] d, input int r, input int c,
                                              input logic l);
        return {9'd0, d, 3'(r), 3'(c), l};
    endfunction

    // Reference model: plain arithmetic over the whole grid sequence.
    task automatic model(input logic [15:0] tl);
        int sc;
        sc       = 0;
        k_exit   = MAX_ITER - 1;
        exp_conv = 1'b0;
        dk[0]    = 0;
        for (int k = 1; k < MAX_ITER; k++) begin
            int m;
            m = 0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    int a;
                    a = int'($signed(g[k][r][c])) - int'($signed(g[k-1][r][c]));
                    if (a < 0) a = -a;
                    if (a > m) m = a;
                end
            end
            dk[k] = m;
            if (DET) begin
                if (m <= int'(tl)) begin
                    if (sc == STABLE - 1) begin
                        k_exit   = k;
                        exp_conv = 1'b1;
                        break;
                    end
                    sc++;
                end else begin
                    sc = 0;
                end
            end
        end
    endtask

    task automatic build_grid(input int pat);
        int base, amp;
        base = int'($urandom_range(0, 1000));
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                g[0][r][c] = (pat == 0) ? 16'h0100 : 16'($urandom);
        for (int k = 1; k < MAX_ITER; k++) begin
            amp = (k < 5) ? 60 : ((k < 8) ? 3 : 0);
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    case (pat)
                        3:       g[k][r][c] = 16'(int'($signed(g[k-1][r][c])) +
                                              int'($urandom_range(0, 2*amp)) - amp);
                        4:       g[k][r][c] = 16'($urandom);
                        default: g[k][r][c] = g[0][r][c];
                    endcase
                end
            end
        end
        for (int k = 0; k < MAX_ITER; k++) begin
            if (pat == 1) g[k][2][3] = 16'(base + ((k % 2) * 2));
            if (pat == 2) g[k][1][4] = (k < 3) ? 16'h7FFF : 16'h8000;
        end
    endtask

    task automatic set_grid(input int k);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                uij[r][c] = g[k][r][c];
    endtask

    task automatic run_solve(input int pat, input logic [15:0] tl, input int rmode,
                             input bit pulses, input bit abort_mid);
        int   d0;
        sum_t s;
        build_grid(pat);
        model(tl);
        for (int i = 0; i < N*N; i++) begin
            word_t w;
            w.w = pack_word(g[k_exit][i/N][i%N], i / N, i % N, i == N*N - 1);
            exp_q.push_back(w);
        end
        s.iter = k_exit;
        s.conv = exp_conv;
        s.md   = DET ? dk[k_exit] : 0;
        sum_q.push_back(s);
        ready_mode = rmode;
        stall_left = 3;
        d0 = done_seen;

        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        tol   = tl;
        tick();
        start = 1'b0;
        tol   = 16'($urandom);
        chk("busy_rise", 32'(busy), 32'd1);
        for (int k = 0; k <= k_exit; k++) begin
            if (k > 0) tick();
            set_grid(k);
            chk("iter_count_run", 32'(iter_count), 32'(k));
            if (k >= 2) chk("max_diff_run", 32'(max_diff), DET ? 32'(dk[k-1]) : 32'd0);
            start = pulses && (k == 2);
        end
        tick();
        start = pulses;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                uij[r][c] = 16'($urandom);
        tick();
        start = 1'b0;

        if (abort_mid) begin
            for (int t = 0; t < 200 && !(out_valid && out_row == 3'd2 && out_col == 3'd0); t++)
                tick();
            chk("abort_reached_word10", {31'd0, out_valid && out_row == 3'd2 && out_col == 3'd0},
                32'd1);
            R = 1'b0;
            #1;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_conv", 32'(converged), 32'd0);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_last", 32'(out_last), 32'd0);
            chk("rst_iter", 32'(iter_count), 32'd0);
            chk("rst_md", 32'(max_diff), 32'd0);
            chk("rst_data", 32'(out_data), 32'd0);
            chk("rst_rowcol", {26'd0, out_row, out_col}, 32'd0);
            exp_q.delete();
            sum_q.delete();
            tick();
            tick();
            #2 R = 1'b1;
            tick();
            chk("abort_no_done", 32'(done_seen), 32'(d0));
        end else begin
            for (int t = 0; t < 400 && done_seen == d0; t++) tick();
            chk("done_seen", 32'(done_seen), 32'(d0 + 1));
            tick();
            chk("idle_after_done", {30'd0, busy, done}, 32'd0);
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
            if (rmode == 2) chk("drain_len_stall", 32'(drain_len), 32'd28);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = random, 2 = three stall cycles on word 7.
    initial begin
        out_ready = 1'b1;
        forever begin
            tick();
            case (ready_mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (out_valid && out_row == 3'd1 && out_col == 3'd2 && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted word and on each stream start.
    initial begin
        bit          in_stream = 0;
        bit          got_last = 0;
        bit          hold_pend = 0;
        logic [31:0] hold_w = '0;
        int          vcyc = 0;
        int          stalls = 0;
        forever begin
            @(negedge CLK);
            if (!R) begin
                in_stream = 0;
                got_last  = 0;
                hold_pend = 0;
                chk("done_in_reset", 32'(done), 32'd0);
            end else begin
                if (hold_pend)
                    chk("hold_stable", {out_valid, pack_word(out_data, out_row, out_col, out_last)},
                        {1'b1, hold_w});
                if (out_valid && !in_stream) begin
                    in_stream = 1;
                    vcyc      = 0;
                    stalls    = 0;
                    checks++;
                    if (sum_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_stream: got out_valid required no stream");
                    end else begin
                        sum_t s;
                        s = sum_q.pop_front();
                        chk("iter_count_final", 32'(iter_count), 32'(s.iter));
                        chk("converged", 32'(converged), 32'(s.conv));
                        chk("max_diff_final", 32'(max_diff), 32'(s.md));
                    end
                end
                if (in_stream && !out_valid && !done)
                    chk("no_bubble", 32'(out_valid), 32'd1);
                if (out_valid) begin
                    vcyc++;
                    chk("busy_in_drain", 32'(busy), 32'd1);
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_word: got %0h required none", out_data);
                    end else begin
                        word_t w;
                        w = exp_q.pop_front();
                        checks--;
                        chk("stream_word", pack_word(out_data, out_row, out_col, out_last), w.w);
                    end
                    got_last = out_last;
                end
                hold_pend = out_valid && !out_ready;
                hold_w    = pack_word(out_data, out_row, out_col, out_last);
                if (hold_pend) stalls++;
                if (done) begin
                    chk("done_after_last", {30'd0, in_stream, got_last}, 32'd3);
                    chk("drain_cycles", 32'(vcyc), 32'(25 + stalls));
                    drain_len = vcyc;
                    in_stream = 0;
                    got_last  = 0;
                    done_seen++;
                end
            end
        end
    end

    initial begin
        R     = 1'b0;
        start = 1'b0;
        tol   = '0;
        uij   = '0;
        #3;
        chk("reset_flags", {27'd0, busy, done, converged, out_valid, out_last}, 32'd0);
        chk("reset_iter", 32'(iter_count), 32'd0);
        chk("reset_md", 32'(max_diff), 32'd0);
        chk("reset_data", {10'd0, out_data, out_row, out_col}, 32'd0);
        #20 R = 1'b1;

        run_solve(0, 16'h0000, 2, 1'b0, 1'b0);   // constant grid, stall on word 7
        run_solve(1, 16'h0001, 0, 1'b0, 1'b0);   // toggling cell, cap exit
        run_solve(2, 16'hFFFE, 1, 1'b0, 1'b0);   // 0x7FFF -> 0x8000 step
        run_solve(0, 16'h0000, 0, 1'b0, 1'b1);   // reset mid-stream at word 10
        run_solve(0, 16'h0000, 1, 1'b1, 1'b0);   // fresh solve, start pulses ignored
        repeat (6) run_solve(3, 16'($urandom_range(0, 8)), 1, 1'b0, 1'b0);
        repeat (3) run_solve(4, 16'($urandom), 1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
